carry_stage_counter: RTL and testbench
======================================

# carry_stage_counter

Second-stage modulo counter that consumes the one-cycle carry/enable produced by an upstream 4-bit counter stage and advances once per asserted carry. It offers free-running and one-shot modes, a small IDLE/RUN/DONE control FSM, synchronous load/clear, and its own carry-out for further cascading. It sits directly downstream of the 4-bit counter stage on the same clock.

## Interface
- `WIDTH`, default 4, count register width; legal only when `MOD <= 2**WIDTH`.
- `MOD`, default 10, modulus; legal range 2..2**WIDTH; the terminal count is `MOD-1`.
- `clk`, in, 1, the single clock; all state updates on its rising edge.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `clr`, in, 1, synchronous clear, highest synchronous priority.
- `start`, in, 1, leaves IDLE or DONE and enters RUN.
- `oneshot`, in, 1, sampled on every terminal wrap; 1 sends the FSM to DONE at the wrap.
- `cin`, in, 1, carry/enable from the upstream stage; each high cycle is one count event.
- `load`, in, 1, synchronous load of `load_val`.
- `load_val`, in, WIDTH, load value; values `>= MOD` are clamped to `MOD-1`.
- `count`, out, WIDTH, current count (registered).
- `cout`, out, 1, combinational carry-out to the next stage.
- `busy`, out, 1, high while the FSM is in RUN.
- `done`, out, 1, high while the FSM is in DONE.
- `ovf`, out, 1, sticky flag marking a carry lost while in DONE.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- While `rst_n` is low, regardless of `clk`:
  - state = IDLE, `count` = 0, `ovf` = 0;
  - hence `busy` = 0, `done` = 0, `cout` = 0.
- FSM states (3; encoding free): IDLE, RUN, DONE. `busy` and `done` decode directly from state.
- Synchronous priority each edge: `clr` > `load` > `start` > `cin`.
- `clr` = 1:
  - `count` <- 0, state <- IDLE, `ovf` <- 0;
  - all other inputs are ignored that cycle.
- `load` = 1 (and `clr` = 0):
  - `count` <- min(`load_val`, `MOD-1`);
  - state is unchanged and any `cin` that cycle is dropped (no count, no `cout`);
  - `start` in the same cycle still applies.
- IDLE:
  - `count` holds and `cin` is ignored;
  - `start` = 1 -> RUN.
- RUN:
  - `cin` = 1 with `count < MOD-1` -> `count` + 1.
  - `cin` = 1 with `count == MOD-1` -> `count` <- 0 (wrap) and `cout` is high that cycle. Then `oneshot` = 1 -> DONE, else the FSM stays in RUN.
  - `start` in RUN is ignored.
- DONE:
  - `count` holds at 0 and `done` = 1.
  - `cin` = 1 -> `ovf` <- 1 (sticky).
  - `start` = 1 -> RUN and `ovf` <- 0; `cin` in that same cycle is not counted.
- `cout` = (state == RUN) & `cin` & (`count` == `MOD-1`) & ~`load` & ~`clr`. It is not registered, so a cascaded stage sees it in the same cycle.
- Arithmetic: unsigned, modulo `MOD`; `count` never holds a value `>= MOD`.

## Timing
- Count latency: `cin` high at edge N -> the new `count` is visible after edge N.
- `cout` is valid in the cycle where `cin` is high and `count == MOD-1`, before edge N.
- `start` at edge N -> `busy` = 1 after edge N. The first countable `cin` is at edge N+1.
- Entry into DONE happens at the same edge as the terminal wrap; `done` = 1 after that edge.
- Back-to-back `cin` (every cycle) is supported with no bubbles.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). Counting resumes only after `rst_n` is high and `start` is asserted.
- Deassertion of `rst_n` must meet recovery timing to `clk`; no internal synchronizer is included.

## Test plan
- Reset/idle: apply reset, release, drive `cin` = 1 for 5 cycles without `start` -> `count` = 0, `busy` = 0, `cout` never high.
- Free-run wrap (MOD=10): `start`, `oneshot` = 0, `cin` = 1 for 12 cycles -> `count` sequence 1..9, 0, 1, 2; `cout` high exactly in the cycle `count` = 9; `busy` stays 1.
- One-shot plus overflow: `start`, `oneshot` = 1, `cin` every cycle -> after the 10th `cin`, `count` = 0 and `done` = 1. Two further `cin` pulses -> `ovf` = 1 and `count` stays 0. `start` -> `ovf` = 0, `busy` = 1.
- Sparse carry: in RUN, `cin` high one cycle in every 16, as from a 4-bit upstream stage -> `count` increments once per pulse; `cout` coincides with the 10th pulse.
- Load/clamp/priority:
  - in RUN, `load_val` = 13 -> `count` = 9;
  - `load` with `cin` at `count` = 9 -> `count` = `load_val` and no `cout`;
  - `clr` with `load` -> `count` = 0, IDLE.
- Async reset mid-run: at `count` = 6, pulse `rst_n` low between edges -> `count` = 0, `busy` = 0 immediately, before the next edge.

Source files
------------

// File: rtl/carry_stage_counter_if.sv
// rtl/carry_stage_counter_if.sv - control and status bundle for the carry-driven second counter stage

interface carry_stage_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             clr;
    logic             start;
    logic             oneshot;
    logic             cin;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             cout;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output clr, start, oneshot, cin, load, load_val,
        input  count, cout, busy, done, ovf
    );

    modport slave (
        input  clr, start, oneshot, cin, load, load_val,
        output count, cout, busy, done, ovf
    );
endinterface

// File: rtl/carry_stage_counter.sv
// rtl/carry_stage_counter.sv - modulo-MOD counter advancing once per upstream carry, with IDLE/RUN/DONE control

module carry_stage_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    carry_stage_counter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             at_max;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (count_q == MAX_CNT);
    assign load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            state_d = ST_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            // A load swallows that cycle's carry but a concurrent start still launches the run.
            count_d = load_clamped;
            if (bus.start && (state_q != ST_RUN)) begin
                state_d = ST_RUN;
                ovf_d   = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.cin) begin
                        if (at_max) begin
                            count_d = '0;
                            if (bus.oneshot) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Restart wins over a coincident carry, which is neither counted nor flagged.
                    if (bus.start) begin
                        state_d = ST_RUN;
                        ovf_d   = 1'b0;
                    end else if (bus.cin) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // Unregistered so a cascaded stage on the same clock counts in this very cycle.
    assign bus.cout  = (state_q == ST_RUN) & bus.cin & at_max & ~bus.load & ~bus.clr;
    assign bus.count = count_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_carry_stage_counter.sv
// tb/tb_carry_stage_counter.sv - vector table and scoreboard bench for carry_stage_counter

module tb_carry_stage_counter;
    logic clk;
    logic rst_n;

    carry_stage_counter_if #(.WIDTH(4)) bus ();

    carry_stage_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, load, start, oneshot, cin;
        logic [3:0] load_val;
        logic [3:0] e_count;
        logic       e_cout, e_busy, e_done, e_ovf;
    } vec_t;

    typedef struct {
        logic [3:0] count;
        logic       busy, done, ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic clr, load, start, oneshot, cin, input logic [3:0] lv,
                       input logic [3:0] ec, input logic ecout, eb, ed, eo);
        vec_t v;
        v.clr = clr; v.load = load; v.start = start; v.oneshot = oneshot; v.cin = cin;
        v.load_val = lv; v.e_count = ec; v.e_cout = ecout; v.e_busy = eb; v.e_done = ed; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.clr = v.clr; bus.load = v.load; bus.start = v.start;
        bus.oneshot = v.oneshot; bus.cin = v.cin; bus.load_val = v.load_val;
        #1;
        check("cout", {31'd0, bus.cout}, {31'd0, v.e_cout});
        e.count = v.e_count; e.busy = v.e_busy; e.done = v.e_done; e.ovf = v.e_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("count", {28'd0, bus.count}, {28'd0, e.count});
            check("busy",  {31'd0, bus.busy},  {31'd0, e.busy});
            check("done",  {31'd0, bus.done},  {31'd0, e.done});
            check("ovf",   {31'd0, bus.ovf},   {31'd0, e.ovf});
        end
    endtask

    task automatic drive_idle();
        bus.clr = 0; bus.load = 0; bus.start = 0; bus.oneshot = 0; bus.cin = 0; bus.load_val = '0;
    endtask

    initial begin
        vec_t v;
        // reset / idle: carries ignored without start
        repeat (5) add(0,0,0,0,1,0, 0,0,0,0,0);
        // free-running wrap
        add(0,0,1,0,0,0, 0,0,1,0,0);
        for (int i = 1; i <= 12; i++) add(0,0,0,0,1,0, 4'(i % 10), (i == 10), 1,0,0);
        add(1,0,0,0,0,0, 0,0,0,0,0);
        // one-shot, overflow, restart
        add(0,0,1,1,0,0, 0,0,1,0,0);
        for (int i = 1; i <= 10; i++) add(0,0,0,1,1,0, 4'(i % 10), (i == 10), (i != 10), (i == 10), 0);
        repeat (2) add(0,0,0,1,1,0, 0,0,0,1,1);
        add(0,0,1,0,1,0, 0,0,1,0,0);
        add(0,0,0,0,1,0, 1,0,1,0,0);
        // load, clamp, priority
        add(0,1,0,0,0,13, 9,0,1,0,0);
        add(0,1,0,0,1,3,  3,0,1,0,0);
        add(0,1,0,0,0,9,  9,0,1,0,0);
        add(0,0,0,0,1,0,  0,1,1,0,0);
        add(1,1,1,0,1,5,  0,0,0,0,0);
        add(0,1,1,0,0,7,  7,0,1,0,0);
        add(0,0,0,0,1,0,  8,0,1,0,0);
        add(0,0,1,0,1,0,  9,0,1,0,0);
        add(1,0,0,0,0,0,  0,0,0,0,0);
        add(0,1,0,0,0,15, 9,0,0,0,0);
        add(0,0,0,0,1,0,  9,0,0,0,0);
        add(1,0,0,0,0,0,  0,0,0,0,0);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {28'd0, bus.count}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_ovf",   {31'd0, bus.ovf},   32'd0);
        check("rst_cout",  {31'd0, bus.cout},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // sparse carry: one pulse every 16 cycles, as from a 4-bit upstream stage
        v = '{clr:0, load:0, start:1, oneshot:0, cin:0, load_val:0, e_count:0, e_cout:0, e_busy:1, e_done:0, e_ovf:0};
        apply(v);
        v.start = 0;
        for (int p = 1; p <= 11; p++) begin
            v.cin = 0; v.e_count = 4'((p - 1) % 10); v.e_cout = 0;
            repeat (15) apply(v);
            v.cin = 1; v.e_count = 4'(p % 10); v.e_cout = (p == 10);
            apply(v);
        end

        // asynchronous reset mid-run at count 6
        v = '{clr:1, load:0, start:0, oneshot:0, cin:0, load_val:0, e_count:0, e_cout:0, e_busy:0, e_done:0, e_ovf:0};
        apply(v);
        v.clr = 0; v.start = 1; v.e_busy = 1;
        apply(v);
        v.start = 0; v.cin = 1;
        for (int i = 1; i <= 6; i++) begin
            v.e_count = 4'(i);
            apply(v);
        end
        @(negedge clk);
        bus.cin = 1;
        #2 rst_n = 1'b0;
        #1;
        check("async_count", {28'd0, bus.count}, 32'd0);
        check("async_busy",  {31'd0, bus.busy},  32'd0);
        check("async_cout",  {31'd0, bus.cout},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{clr:0, load:0, start:0, oneshot:0, cin:1, load_val:0, e_count:0, e_cout:0, e_busy:0, e_done:0, e_ovf:0};
        repeat (2) apply(v);
        v.start = 1; v.cin = 0; v.e_busy = 1;
        apply(v);
        v.start = 0; v.cin = 1; v.e_count = 1;
        apply(v);

        if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
